// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for program_sequencer; SEQ_SINGLE_STEP_EN adds the PAUSE state
package seq_pkg;
  localparam int DEF_DW    = 10;
  localparam int DEF_DEPTH = 16;

  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_SUBI = 2'b11;
  localparam logic [3:0] LD_FUNC = 4'b0000;

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_PAUSE} seq_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;
`endif

  // ld is the only instruction that pulls an operand word after its opcode
  function automatic logic is_ld(input logic [DEF_DW-1:0] w);
    return (w[9:8] == OP_REG) && (w[3:0] == LD_FUNC);
  endfunction
endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - DEPTH x DW program store, synchronous write, asynchronous read
module prog_mem #(
  parameter int DW    = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - feeds stored program words to the processor data input, one per ext strobe
// Optional single-step PAUSE state compiled in with SEQ_SINGLE_STEP_EN.
import seq_pkg::*;

module program_sequencer #(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_wdata,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          step,
  input  logic          ext,
  input  logic          clr,
  output logic [DW-1:0] data,
  output logic          proc_run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);
  localparam int          AW1     = AW + 1;
  localparam logic [AW:0] DEPTH_W = AW1'(DEPTH);
  localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

  seq_state_t    state, state_nx;
  logic [AW-1:0] pc_r;
  logic [AW:0]   len_r;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   start_len;
  logic          run_st;
  logic          can_start;
  logic          last;
  logic [DW-1:0] rdata;

  assign run_st    = (state == S_RUN);
  assign can_start = (state == S_IDLE) || (state == S_DONE);
  assign start_len = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
  // word on this same edge counts before the stop test; saturate so stray ext never wraps the count
  assign cnt_inc   = (ext && (cnt_r != '1)) ? cnt_r + 1'b1 : cnt_r;
  assign last      = (cnt_inc >= len_r);

`ifdef SEQ_SINGLE_STEP_EN
  assign busy = run_st || (state == S_PAUSE);
`else
  logic unused_step;
  assign unused_step = step;
  assign busy = run_st;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef SEQ_SINGLE_STEP_EN
          state_nx = (start_len == '0) ? S_DONE : S_PAUSE;
`else
          state_nx = (start_len == '0) ? S_DONE : S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (clr) begin
`ifdef SEQ_SINGLE_STEP_EN
          state_nx = last ? S_DONE : S_PAUSE;
`else
          state_nx = last ? S_DONE : S_RUN;
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_nx = S_RUN;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc_r  <= '0;
      len_r <= '0;
      cnt_r <= '0;
    end else begin
      state <= state_nx;
      if (can_start && start) begin
        pc_r  <= '0;
        len_r <= start_len;
        cnt_r <= '0;
      end else if (run_st && ext) begin
        pc_r  <= (pc_r == PC_MAX) ? '0 : pc_r + 1'b1;
        cnt_r <= cnt_inc;
      end
    end
  end

  prog_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc_r),
    .rdata (rdata)
  );

  assign data     = busy ? rdata : '0;
  assign proc_run = run_st;
  assign done     = (state == S_DONE);
  assign pc       = pc_r;
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized scoreboard bench for program_sequencer
module tb_program_sequencer;
  import seq_pkg::*;

  localparam int DW = 10, DEPTH = 16, AW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          prog_we = 1'b0, start = 1'b0, step = 1'b0, ext = 1'b0, clr = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic [AW:0]   prog_len = '0;
  logic [DW-1:0] data;
  logic          proc_run, busy, done;
  logic [AW-1:0] pc;

  int errs = 0, checks = 0;
  logic [DW-1:0] mdl [DEPTH];

  typedef struct packed {
    logic [DW-1:0] w;
    logic [AW-1:0] a;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  program_sequencer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_len(prog_len), .start(start), .step(step), .ext(ext), .clr(clr),
    .data(data), .proc_run(proc_run), .pc(pc), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    prog_addr = a[AW-1:0]; prog_wdata = d; prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic cyc(input logic e, input logic c);
    ext = e; clr = c;
    @(posedge clk); #1;
    ext = 1'b0; clr = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return {OP_REG, 4'($urandom), LD_FUNC};
      1:       return {OP_ADDI, 8'($urandom)};
      2:       return {OP_SUBI, 8'($urandom)};
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic push(input int a);
    sbq.push_back({mdl[a], a[AW-1:0]});
  endtask

  // Controller model: ld = ext@T0, ext+clr@T1; others = ext@T0, clr after gap idle cycles
  task automatic run_prog(input int n, input int gap, input bit wr_busy);
    int len = (n > DEPTH) ? DEPTH : n;
    int issued = 0;
    int mpc = 0;
    prog_len = n[AW:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_run", proc_run, 0);
      chk("len0_pc", pc, 0);
      cyc(1'b0, 1'b0);
      chk("len0_run_later", proc_run, 0);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_data", data, mdl[0]);
    if (wr_busy) begin
      prog_addr = 4'd5; prog_wdata = ~mdl[5]; prog_we = 1'b1;
      @(posedge clk); #1;
      prog_we = 1'b0;
    end
`ifdef SEQ_SINGLE_STEP_EN
    chk("start_paused", proc_run, 0);
    pulse_step();
`endif
    chk("start_run", proc_run, 1);
    while (issued < len) begin
      if (is_ld(mdl[mpc]) && (len - issued) >= 2) begin
        push(mpc); cyc(1'b1, 1'b0); mpc = (mpc + 1) % DEPTH; issued++;
        push(mpc); cyc(1'b1, 1'b1); mpc = (mpc + 1) % DEPTH; issued++;
      end else begin
        push(mpc);
        if (gap == 0) cyc(1'b1, 1'b1);
        else begin
          cyc(1'b1, 1'b0);
          repeat (gap - 1) cyc(1'b0, 1'b0);
          cyc(1'b0, 1'b1);
        end
        mpc = (mpc + 1) % DEPTH; issued++;
      end
      if (issued < len) begin
`ifdef SEQ_SINGLE_STEP_EN
        chk("pause_after_clr", proc_run, 0);
        chk("pause_data", data, mdl[mpc]);
        pulse_step();
`endif
        chk("still_run", proc_run, 1);
      end
    end
    chk("end_done", done, 1);
    chk("end_run", proc_run, 0);
    chk("end_busy", busy, 0);
    chk("end_data", data, 0);
    chk("end_pc", pc, mpc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (ext && !rst) begin
          chk("run_on_ext", proc_run, 1);
          chk("sb_nonempty", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("data", data, mon_e.w);
            chk("pc", pc, mon_e.a);
          end
        end
      end
    join_none

    @(posedge clk); #1;
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_run", proc_run, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) wr(i, rand_word());
    wr(0, 10'h000); wr(1, 10'h005); wr(2, 10'h203);
    run_prog(3, 3, 1'b0);
    cyc(1'b0, 1'b0);
    chk("done_held", done, 1);

    run_prog(0, 0, 1'b0);

    wr(5, 10'h2AA);
    run_prog(3, 3, 1'b1);
    run_prog(8, 1, 1'b0);

    // reset in the middle of a run
    prog_len = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    pulse_step();
`endif
    push(0); cyc(1'b1, 1'b0);
    chk("mid_pc", pc, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_pc", pc, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data", data, 0);
    chk("mrst_run", proc_run, 0);
    chk("mrst_done", done, 0);
    run_prog(3, 3, 1'b0);

    for (int i = 0; i < DEPTH; i++) wr(i, {OP_ADDI, 8'($urandom)});
    run_prog(16, 0, 1'b0);

    run_prog(20, $urandom_range(0, 3), 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, rand_word());
      run_prog($urandom_range(1, 16), $urandom_range(0, 3), 1'b0);
    end

    repeat (2) cyc(1'b0, 1'b0);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Feeds a stored program into the 10-bit processor's external data input, one word per processor consume strobe. Holds a small writable program memory, steps a program counter each time the controller consumes the bus (Ext high), and tracks instruction completion (Clr high) to stop after a set number of words. It sits on the processor's external "data" side, producing exactly the words the controller's T0 and T1 steps consume. It also supplies a run-gate that holds the processor's timestep counter while idle.

## Interface
- DW, 10, data/instruction word width
- DEPTH, 16, program memory words
- AW, 4, address width, $clog2(DEPTH)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- prog_we  in  1  write strobe for program memory
- prog_addr  in  AW  write address
- prog_wdata  in  DW  write data
- prog_len  in  AW+1  number of words to issue, sampled on start, 0..DEPTH
- start  in  1  single-cycle pulse: begin run from address 0
- step  in  1  single-step advance pulse; used only with SEQ_SINGLE_STEP_EN
- ext  in  1  processor Ext: data word consumed this cycle
- clr  in  1  processor Clr: instruction completes this cycle
- data  out  DW  word driven onto processor external data input
- proc_run  out  1  enable for the processor timestep counter and IRin
- pc  out  AW  current program address
- busy  out  1  run in progress
- done  out  1  run finished, held until next start or reset

## Operation
- States: IDLE, RUN, DONE; PAUSE exists only with SEQ_SINGLE_STEP_EN.
- IDLE: prog_we writes mem[prog_addr] <= prog_wdata on the clock edge. start latches len = min(prog_len, DEPTH), sets pc = 0, and moves to RUN.
- start with latched len 0: go directly to DONE. proc_run never asserts.
- RUN: proc_run = 1 and data = mem[pc], with combinational read. On each edge with ext = 1, pc <= pc + 1, wrapping DEPTH-1 to 0. An ld instruction therefore consumes two words, the opcode and then the operand. All other instructions consume one.
- RUN, edge with clr = 1: if words issued (including any ext on this same cycle) >= len, go to DONE. Otherwise stay in RUN.
- ext and clr on the same cycle (ld at T1): count the word first, then evaluate the stop condition.
- DONE: proc_run = 0 and done = 1. start restarts the run exactly as from IDLE. prog_we writes are allowed.
- prog_we while busy: ignored, memory unchanged.
- start while busy: ignored.
- ext or clr outside RUN: ignored.
- When not in RUN, data = 0.

## Timing
- Reset values: state IDLE, pc 0, len 0, data 0, proc_run 0, busy 0, done 0. Memory contents are not reset.
- rst mid-run: the next cycle is IDLE with all outputs at reset values, and the program is retained.
- start to proc_run = 1: 1 cycle. data is valid in the same cycle proc_run rises.
- data follows pc combinationally, so the word is stable in the cycle ext samples it.
- Final clr to proc_run = 0 and done = 1: 1 cycle.
- busy = 1 exactly in RUN, plus PAUSE when compiled.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - start enters PAUSE instead of RUN.
  - Every non-final clr moves RUN to PAUSE.
  - PAUSE holds proc_run = 0 and keeps data = mem[pc].
  - A step pulse moves PAUSE to RUN.
  - A final clr still goes to DONE.
- SEQ_SINGLE_STEP_EN undefined: no PAUSE state, and step is ignored.

## Structure
- Package seq_pkg:
  - seq_state_t enum.
  - Opcode-class constants: OP_REG = 2'b00, OP_ADDI = 2'b10, OP_SUBI = 2'b11, LD_FUNC = 4'b0000.
  - Default DW and DEPTH.
- Sub-module prog_mem: DEPTH x DW, synchronous write, asynchronous read, instantiated once.

## Test plan
- Program mem[0]=10'h000 (ld R0), mem[1]=10'h005, mem[2]=10'h203 (addi R0,3); prog_len=3; bench drives ld as ext@T0, ext+clr@T1, and addi as ext@T0, clr@T3.
  - Expect data sequence 0x000, 0x005, 0x203.
  - Expect pc 0→1→2→3.
  - Expect done=1 one cycle after the addi clr.
- prog_len=0 with start: next cycle done=1, proc_run never 1, pc=0.
- prog_we to addr 5 while busy: mem[5] unchanged, verified by a later run.
- rst asserted mid-run at pc=1: next cycle pc=0, busy=0, data=0. A following start replays from address 0 with the same words.
- prog_len=16, with ext on every cycle: pc wraps 15→0, and done follows the clr after the 16th word.
- With SEQ_SINGLE_STEP_EN:
  - Use the first test's program.
  - After each non-final clr, proc_run=0 until step. Each step resumes for exactly one instruction.
  - The final clr gives done=1 without any step.
